// File: rtl/scenario_sequencer_if.sv
// Load handshake bundle between the scenario sequencer and the physics engine.
// One beat carries one sprite's location and velocity vectors.
`timescale 1ns/1ps
interface scenario_sequencer_if #(
  parameter int SPRITES    = 4,
  parameter int DIMENSIONS = 2,
  parameter int WIDTH      = 32
);
  localparam int IW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int DW = DIMENSIONS * WIDTH;

  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_idx;
  logic [DW-1:0] ld_loc;
  logic [DW-1:0] ld_vel;

  modport master (
    output ld_valid, ld_idx, ld_loc, ld_vel,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_idx, ld_loc, ld_vel,
    output ld_ready
  );
endinterface

// File: rtl/scenario_sequencer.sv
// Debounces scenario switches, selects initial conditions and streams them.
// Define SCENARIO_AUTO_RESTART_EN to reload automatically on switch change in RUN.
`timescale 1ns/1ps
module scenario_sequencer #(
  parameter int SPRITES       = 4,
  parameter int DIMENSIONS    = 2,
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                clock_162,
  input  logic                                rst,
  input  logic [15:0]                         sw,
  input  logic                                start,
  output logic [15:0]                         sel_out,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] loc_in,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] vel_in,
  scenario_sequencer_if.master                ld,
  output logic                                eng_en,
  output logic                                busy
);
  localparam int IW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int DW = DIMENSIONS * WIDTH;

  typedef enum logic [1:0] {IDLE, SETTLE, LOAD, RUN} state_t;

  state_t        state;
  logic [15:0]   sw_q;
  logic [15:0]   sw_stable;
  logic [15:0]   stable_cnt;
  logic          pending;
  logic          start_q;
  logic [7:0]    settle_cnt;
  logic          valid_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] loc_q;
  logic [DW-1:0] vel_q;

  logic [DW-1:0] loc_arr [SPRITES];
  logic [DW-1:0] vel_arr [SPRITES];
  logic [IW-1:0] idx_nxt;
  logic          start_rise;
  logic          accept;
  logic          run_go;
  logic          enter;
  logic          beat;
  logic          last;

  assign start_rise = start & ~start_q;
  assign accept     = (stable_cnt == 16'(STABLE_CYCLES - 1)) &&
                      (sw_q != sw_stable);
  assign idx_nxt    = idx_q + IW'(1);
  assign last       = (idx_q == IW'(SPRITES - 1));
  assign beat       = valid_q & ld.ld_ready;

`ifdef SCENARIO_AUTO_RESTART_EN
  assign run_go = start_rise | pending;
`else
  assign run_go = start_rise;
`endif

  assign enter = ((state == IDLE) & (start_rise | pending)) |
                 ((state == RUN) & run_go);

  assign ld.ld_valid = valid_q;
  assign ld.ld_idx   = idx_q;
  assign ld.ld_loc   = loc_q;
  assign ld.ld_vel   = vel_q;

  // Split the flat selector buses into per-sprite vectors.
  always_comb begin
    for (int i = 0; i < SPRITES; i++) begin
      loc_arr[i] = loc_in[i*DW +: DW];
      vel_arr[i] = vel_in[i*DW +: DW];
    end
  end

  // Switch debounce: count consecutive cycles the raw switches match sw_q.
  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      sw_q       <= '0;
      stable_cnt <= '0;
    end else begin
      sw_q <= sw;
      if (sw != sw_q)
        stable_cnt <= '0;
      else if (stable_cnt != 16'hffff)
        stable_cnt <= stable_cnt + 16'd1;
    end
  end

  // Sequencer FSM; a new accepted code wins over a clear on SETTLE entry.
  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_out    <= '0;
      sw_stable  <= '0;
      pending    <= 1'b0;
      start_q    <= 1'b0;
      settle_cnt <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      loc_q      <= '0;
      vel_q      <= '0;
      eng_en     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      start_q <= start;
      if (accept)
        sw_stable <= sw_q;
      unique case (state)
        IDLE, RUN: begin
          if (enter) begin
            state      <= SETTLE;
            sel_out    <= sw_stable;
            pending    <= 1'b0;
            settle_cnt <= '0;
            idx_q      <= '0;
            eng_en     <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
            state   <= LOAD;
            valid_q <= 1'b1;
            loc_q   <= loc_arr[0];
            vel_q   <= vel_arr[0];
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        LOAD: begin
          if (beat) begin
            if (last) begin
              state   <= RUN;
              valid_q <= 1'b0;
              idx_q   <= '0;
              busy    <= 1'b0;
              eng_en  <= 1'b1;
            end else begin
              idx_q <= idx_nxt;
              loc_q <= loc_arr[idx_nxt];
              vel_q <= vel_arr[idx_nxt];
            end
          end
        end
      endcase
      if (accept)
        pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_scenario_sequencer.sv
// Scoreboard bench for scenario_sequencer with a behavioural selector model.
// Build with SCENARIO_AUTO_RESTART_EN to cover the auto-restart variant.
`timescale 1ns/1ps
module tb_scenario_sequencer;
  localparam int S  = 4;
  localparam int D  = 2;
  localparam int W  = 32;
  localparam int DW = D * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     sw = '0;
  logic            start = 1'b0;
  logic [15:0]     sel_out;
  logic [S*DW-1:0] loc_in;
  logic [S*DW-1:0] vel_in;
  logic            eng_en;
  logic            busy;

  scenario_sequencer_if #(.SPRITES(S), .DIMENSIONS(D), .WIDTH(W)) ld_if();

  scenario_sequencer #(
    .SPRITES(S), .DIMENSIONS(D), .WIDTH(W),
    .STABLE_CYCLES(1024), .SETTLE_CYCLES(4)
  ) dut (
    .clock_162(clk),
    .rst(rst),
    .sw(sw),
    .start(start),
    .sel_out(sel_out),
    .loc_in(loc_in),
    .vel_in(vel_in),
    .ld(ld_if),
    .eng_en(eng_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] loc;
    logic [DW-1:0] vel;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic logic [31:0] coord(input int k, input int s,
                                        input int i, input int d);
    if (k == 0 && i == 1)
      return 32'hff00_0000 | s;
    return {k[3:0], s[11:0], i[7:0], d[7:0]};
  endfunction

  function automatic beat_t mk(input int s, input int i);
    beat_t b;
    b.idx = i[1:0];
    b.loc = {coord(0, s, i, 1), coord(0, s, i, 0)};
    b.vel = {coord(1, s, i, 1), coord(1, s, i, 0)};
    return b;
  endfunction

  // Initial-condition selector model.
  always_comb begin
    loc_in = '0;
    vel_in = '0;
    for (int i = 0; i < S; i++)
      for (int d = 0; d < D; d++) begin
        loc_in[(i*D+d)*W +: W] = coord(0, int'(sel_out), i, d);
        vel_in[(i*D+d)*W +: W] = coord(1, int'(sel_out), i, d);
      end
  end

  task automatic push_load(input int s);
    for (int i = 0; i < S; i++)
      exp_q.push_back(mk(s, i));
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Record beats until the engine is enabled after a load.
  task automatic observe(input int max_cyc, input int stall_idx,
                         input int stall_len, output int settle_n,
                         output int stall_err, output bit to);
    bit    stalled;
    beat_t snap;
    settle_n  = 0;
    stall_err = 0;
    to        = 1'b1;
    stalled   = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (eng_en && !ld_if.ld_valid && obs_q.size() > 0) begin
        to = 1'b0;
        break;
      end
      if (busy && !ld_if.ld_valid)
        settle_n++;
      if (ld_if.ld_valid && !stalled && stall_len > 0 &&
          int'(ld_if.ld_idx) == stall_idx) begin
        stalled = 1'b1;
        snap = {ld_if.ld_idx, ld_if.ld_loc, ld_if.ld_vel};
        ld_if.ld_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          if (ld_if.ld_valid !== 1'b1 ||
              {ld_if.ld_idx, ld_if.ld_loc, ld_if.ld_vel} !== snap)
            stall_err++;
        end
        ld_if.ld_ready = 1'b1;
      end
      if (ld_if.ld_valid && ld_if.ld_ready)
        obs_q.push_back({ld_if.ld_idx, ld_if.ld_loc, ld_if.ld_vel});
    end
  endtask

  task automatic test_reset;
    int act;
    ld_if.ld_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ld_if.ld_valid !== 1'b0 || ld_if.ld_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_ld valid=%b idx=%0d want 0 0",
               ld_if.ld_valid, ld_if.ld_idx);
    end
    total++;
    if ({ld_if.ld_loc, ld_if.ld_vel} !== '0 || sel_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_data loc=%h vel=%h sel=%h want 0",
               ld_if.ld_loc, ld_if.ld_vel, sel_out);
    end
    total++;
    if (eng_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags eng_en=%b busy=%b want 0 0", eng_en, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || eng_en || ld_if.ld_valid) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL reset_idle active_cycles=%0d want 0", act);
    end
  endtask

  task automatic test_basic;
    int sn, se, n;
    bit to;
    beat_t e, o;
    sw = 16'd0;
    obs_q.delete();
    push_load(0);
    pulse_start();
    observe(200, -1, 0, sn, se, to);
    total++;
    if (to || sn != 4) begin
      bad++;
      $display("FAIL basic_settle timeout=%0d settle=%0d want 0 4", to, sn);
    end
    total++;
    if (obs_q.size() < 2 || obs_q[1].loc !== 64'hff00_0000_ff00_0000) begin
      bad++;
      $display("FAIL basic_sprite1 beats=%0d want ff000000ff000000",
               obs_q.size());
    end
    n = obs_q.size();
    total++;
    if (n != S) begin
      bad++;
      $display("FAIL basic_beats got=%0d want=%0d", n, S);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic_beat got %h want %h", o, e);
      end
    end
    total++;
    if (eng_en !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_run eng_en=%b busy=%b want 1 0", eng_en, busy);
    end
  endtask

  task automatic test_debounce;
    int early, first, sn, se;
    bit to;
    beat_t e, o;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sw = 16'd1;
    early = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sel_out !== 16'd0 || busy !== 1'b0) early++;
      @(posedge clk); #1;
      if (c == 99) sw = 16'd0;
      if (c == 199) sw = 16'd1;
    end
    first = 0;
    for (int j = 1; j <= 1100; j++) begin
      @(negedge clk);
      if (sel_out === 16'd1) begin
        first = j;
        break;
      end
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL debounce_early glitch_cycles=%0d want 0", early);
    end
    total++;
    if (first != 1027) begin
      bad++;
      $display("FAIL debounce_accept cycle=%0d want 1027", first);
    end
    obs_q.delete();
    push_load(1);
    observe(200, -1, 0, sn, se, to);
    total++;
    if (to || sn != 3 || obs_q.size() != S) begin
      bad++;
      $display("FAIL debounce_load to=%0d settle=%0d beats=%0d want 0 3 4",
               to, sn, obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL debounce_beat got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_stall;
    int sn, se;
    bit to;
    beat_t e, o;
    obs_q.delete();
    push_load(1);
    pulse_start();
    observe(300, 2, 10, sn, se, to);
    total++;
    if (se != 0) begin
      bad++;
      $display("FAIL stall_hold changed_cycles=%0d want 0", se);
    end
    total++;
    if (to || obs_q.size() != S) begin
      bad++;
      $display("FAIL stall_beats to=%0d beats=%0d want 0 4",
               to, obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL stall_beat got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_run_pending;
    int sn, se, extra;
    bit to;
    beat_t e, o;
    @(posedge clk); #1 sw = 16'd2;
    obs_q.delete();
`ifdef SCENARIO_AUTO_RESTART_EN
    push_load(2);
    observe(1300, -1, 0, sn, se, to);
    total++;
    if (to || sn != 4 || sel_out !== 16'd2) begin
      bad++;
      $display("FAIL auto_reload to=%0d settle=%0d sel=%0d want 0 4 2",
               to, sn, sel_out);
    end
`else
    extra = 0;
    repeat (1200) begin
      @(negedge clk);
      if (!eng_en || busy) extra++;
    end
    total++;
    if (extra != 0 || sel_out !== 16'd1) begin
      bad++;
      $display("FAIL hold_pending drop_cycles=%0d sel=%0d want 0 1",
               extra, sel_out);
    end
    push_load(2);
    pulse_start();
    observe(200, -1, 0, sn, se, to);
    total++;
    if (to || sn != 4 || sel_out !== 16'd2) begin
      bad++;
      $display("FAIL start_reload to=%0d settle=%0d sel=%0d want 0 4 2",
               to, sn, sel_out);
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pending_beat got %h want %h", o, e);
      end
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ld_if.ld_valid || busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL pending_consumed reload_cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_ignore_reset;
    int sn, se, extra;
    bit to, hit;
    beat_t e, o;
    obs_q.delete();
    push_load(2);
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (ld_if.ld_valid && ld_if.ld_ready)
        obs_q.push_back({ld_if.ld_idx, ld_if.ld_loc, ld_if.ld_vel});
      if (ld_if.ld_valid && ld_if.ld_idx == 2'd1) begin
        hit = 1'b1;
        start = 1'b1;
      end
    end
    @(posedge clk); #1 start = 1'b0;
    observe(100, -1, 0, sn, se, to);
    total++;
    if (!hit || to || obs_q.size() != S) begin
      bad++;
      $display("FAIL ignore_beats hit=%0d to=%0d beats=%0d want 1 0 4",
               hit, to, obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ignore_beat got %h want %h", o, e);
      end
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ld_if.ld_valid || busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_queued reload_cycles=%0d want 0", extra);
    end
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (ld_if.ld_valid && ld_if.ld_idx == 2'd2) begin
        hit = 1'b1;
        rst = 1'b1;
      end
    end
    #1;
    total++;
    if (!hit || ld_if.ld_valid !== 1'b0 || ld_if.ld_idx !== 2'd0) begin
      bad++;
      $display("FAIL abort_ld hit=%0d valid=%b idx=%0d want 1 0 0",
               hit, ld_if.ld_valid, ld_if.ld_idx);
    end
    total++;
    if ({ld_if.ld_loc, ld_if.ld_vel} !== '0 || sel_out !== 16'd0 ||
        eng_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_out sel=%h eng_en=%b busy=%b want 0",
               sel_out, eng_en, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ld_if.ld_valid || busy || eng_en) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL abort_idle active_cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_coincident;
    int sn, se, extra;
    bit to, hit;
    beat_t e, o;
    hit = 1'b0;
    for (int c = 0; c < 1200 && !hit; c++) begin
      @(negedge clk);
      if (dut.pending === 1'b1) hit = 1'b1;
    end
    start = 1'b1;
    obs_q.delete();
    push_load(2);
    @(posedge clk); #1 start = 1'b0;
    observe(200, -1, 0, sn, se, to);
    total++;
    if (!hit || to || sn != 4 || obs_q.size() != S) begin
      bad++;
      $display("FAIL both_load hit=%0d to=%0d settle=%0d beats=%0d want 1 0 4 4",
               hit, to, sn, obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL both_beat got %h want %h", o, e);
      end
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ld_if.ld_valid || busy) extra++;
    end
    total++;
    if (extra != 0 || dut.pending !== 1'b0) begin
      bad++;
      $display("FAIL both_single reload_cycles=%0d pending=%b want 0 0",
               extra, dut.pending);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_debounce();
    test_stall();
    test_run_pending();
    test_ignore_reset();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scenario_sequencer.md
SCENARIO_SEQUENCER -- requirements
Module: scenario_sequencer

Interface
REQ-001 Parameter SPRITES, default 4, number of sprites loaded per scenario.
REQ-002 Parameter DIMENSIONS, default 2, axes per sprite vector.
REQ-003 Parameter WIDTH, default 32, bits per fixed-point coordinate.
REQ-004 Parameter STABLE_CYCLES, default 1024, cycles switches must hold still before a new selection is accepted (range 2..65535).
REQ-005 Parameter SETTLE_CYCLES, default 4, cycles waited after driving sel_out before sampling loc_in/vel_in (range 1..255).
REQ-006 clock_162  in  1  single system clock, all state on rising edge.
REQ-007 rst  in  1  reset; asynchronous and active-high.
REQ-008 sw  in  16  raw scenario switches (asynchronous, bouncy).
REQ-009 start  in  1  (re)start button level, synchronised upstream.
REQ-010 sel_out  out  16  accepted scenario code driven to the initial-condition selector.
REQ-011 loc_in, vel_in  in  SPRITES*DIMENSIONS*WIDTH each  initial locations/velocities returned by the selector, sprite 0 in LSBs.
REQ-012 ld_valid  out  1 / ld_ready  in  1  load handshake toward the physics engine.
REQ-013 ld_idx  out  $clog2(SPRITES)  sprite index of current load beat.
REQ-014 ld_loc, ld_vel  out  DIMENSIONS*WIDTH each  location/velocity of sprite ld_idx.
REQ-015 eng_en  out  1  physics engine run enable.
REQ-016 busy  out  1  high in SETTLE or LOAD.

Function
REQ-017 Debounce: sw registered into sw_q; 16-bit counter clears when sw != sw_q, else increments, saturating at 65535.
REQ-018 When counter == STABLE_CYCLES-1 and sw_q != sw_stable, sw_stable <= sw_q and pending <= 1 on the same edge.
REQ-019 start_rise = start & ~start_q (start_q registered).
REQ-020 FSM states IDLE, SETTLE, LOAD, RUN; eng_en = (state == RUN) only.
REQ-021 IDLE: start_rise or pending -> SETTLE.
REQ-022 Entry to SETTLE: sel_out <= sw_stable, pending <= 0, settle counter <= 0, ld_idx <= 0.
REQ-023 SETTLE: after SETTLE_CYCLES cycles in state -> LOAD.
REQ-024 LOAD: ld_valid = 1; ld_loc/ld_vel = slice ld_idx of loc_in/vel_in, registered, stable while ld_valid & ~ld_ready.
REQ-025 Beat transfers on a cycle with ld_valid & ld_ready; ld_idx increments; beat with ld_idx == SPRITES-1 -> RUN, ld_valid low next cycle, ld_idx <= 0.
REQ-026 Exactly SPRITES beats per load; no gaps required, ld_ready may stall indefinitely.
REQ-027 RUN: start_rise -> SETTLE (reload current sw_stable); pending handling per REQ-033/034.
REQ-028 start_rise in SETTLE or LOAD is ignored, not queued.
REQ-029 pending set during SETTLE or LOAD stays set and is evaluated on reaching RUN.
REQ-030 start_rise and pending in the same cycle cause one reload; pending cleared.

Reset
REQ-031 rst asserted: state IDLE, sel_out 0, sw_q 0, sw_stable 0, pending 0, counters 0, start_q 0, ld_valid 0, ld_idx 0, ld_loc/ld_vel 0, eng_en 0, busy 0; mid-load beats abandoned immediately.
REQ-032 First edge after rst deassertion evaluates normally; no reload without start_rise or pending.

Configuration
REQ-033 Macro SCENARIO_AUTO_RESTART_EN defined: in RUN, pending -> SETTLE (switch change restarts simulation automatically).
REQ-034 Macro undefined: in RUN pending is held and consumed only by the next start_rise; IDLE behaviour unchanged.

Verification
REQ-035 rst, sw=0, start pulse, ld_ready=1 -> SETTLE 4 cycles, 4 beats ld_idx 0..3, sprite 1 ld_loc = {32'hff00_0000,32'hff00_0000} on scenario-0 data, then eng_en=1.
REQ-036 sw toggles 0->1->0->1 every 100 cycles then holds 1 -> sel_out stays 0 until 1024 stable cycles, then sel_out=1.
REQ-037 ld_ready low 10 cycles during beat 2 -> ld_valid, ld_idx=2, ld_loc/ld_vel unchanged throughout stall; total beats 4.
REQ-038 In RUN, sw 1->2 stable -> with SCENARIO_AUTO_RESTART_EN reload with sel_out=2, eng_en drops; without it eng_en stays 1 until start pulse.
REQ-039 start pulse in LOAD at beat 1 -> ignored, one load only; rst at beat 2 -> all outputs 0 next cycle, state IDLE.
REQ-040 start_rise coincident with pending in IDLE -> single SETTLE entry, pending=0, exactly 4 beats.
